bcd_serial_accum: RTL and testbench
===================================

BCD_SERIAL_ACCUM -- requirements
Module: bcd_serial_accum

Interface
REQ-001 Parameter: DIGITS, default 4, number of packed BCD digits (legal range 1..8).
REQ-002 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst_n: input, 1 bit; reset is asynchronous and active-low.
REQ-004 Port in_valid: input, 1 bit, command/operand present.
REQ-005 Port in_ready: output, 1 bit, block can accept a command this cycle.
REQ-006 Port in_op: input, 2 bits, command: 00 ADD, 01 LOAD, 10 CLEAR, 11 reserved.
REQ-007 Port in_bcd: input, 4*DIGITS bits, packed BCD operand; digit 0 in bits [3:0].
REQ-008 Port acc: output, 4*DIGITS bits, committed packed BCD accumulator value.
REQ-009 Port acc_ovf: output, 1 bit, sticky decimal overflow flag.
REQ-010 Port done: output, 1 bit, one-cycle pulse on command completion.
REQ-011 Port err: output, 1 bit, one-cycle pulse on command rejection.
REQ-012 Port busy: output, 1 bit, ADD in progress.

Function
REQ-013 Accept a command only when in_valid and in_ready are both 1 on a rising edge; in_ready SHALL equal (state == IDLE).
REQ-014 State machine: IDLE and ADD only; any other encoding SHALL return to IDLE.
REQ-015 ADD accept at cycle T: latch in_bcd, digit index <= 0, carry <= 0, go to ADD.
REQ-016 ADD state: process one digit per cycle, LSD first: work digit[idx] <= BCD sum of acc digit[idx], operand digit[idx] and carry; carry <= digit carry-out.
REQ-017 ADD ends after exactly DIGITS cycles (T+1..T+DIGITS); on the edge closing cycle T+DIGITS: acc <= work register, state <= IDLE, done <= 1.
REQ-018 Completion overflow: if the final digit carry-out is 1, acc_ovf SHALL be set (sticky); acc holds the sum modulo 10^DIGITS.
REQ-019 acc SHALL NOT change during ADD; the update is atomic at completion.
REQ-020 busy SHALL be 1 in cycles T+1..T+DIGITS, and 0 otherwise.
REQ-021 LOAD accept at T: acc <= in_bcd, acc_ovf <= 0, done = 1 in T+1, stay IDLE.
REQ-022 CLEAR accept at T: acc <= 0, acc_ovf <= 0, done = 1 in T+1, stay IDLE; in_bcd is ignored.
REQ-023 Input check: for ADD or LOAD, if any in_bcd digit > 9, reject: err = 1 in T+1, no done, and acc, acc_ovf and state unchanged.
REQ-024 Reserved op 11: reject with err = 1 in T+1, no state change.
REQ-025 done and err SHALL never both be 1 in the same cycle.
REQ-026 Back-to-back: a new command accepted in the cycle done is high SHALL see the updated acc.
REQ-027 Digit adder: binary sum s of the two digits plus carry (0..19); if s > 9, output s+6 (low 4 bits) with carry 1, else output s with carry 0.

Reset
REQ-028 On rst_n = 0, immediately and regardless of clk, clear: state = IDLE, acc = 0, acc_ovf = 0, done = 0, err = 0, busy = 0, idx = 0, carry = 0, work register = 0.
REQ-029 Reset during ADD SHALL discard the partial sum; no done is issued after reset release.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-031 Shared package: op encodings (ADD/LOAD/CLEAR/RSVD), state encoding, BCD digit width constant 4.
REQ-032 One sub-module, bcd_digit_add: combinational single-digit BCD adder (a, b, cin -> sum, cout) per REQ-027, instantiated once and time-shared across digits.

Verification
REQ-033 Reset, then LOAD 1234, then ADD 0766 (DIGITS = 4): acc = 2000 exactly 4 cycles after ADD accept plus the done cycle; acc_ovf = 0; busy high for 4 cycles.
REQ-034 LOAD 9999, then ADD 0001: acc = 0000, acc_ovf = 1, done 1 pulse; then CLEAR: acc = 0000, acc_ovf = 0.
REQ-035 ADD with in_bcd = 12A4: err = 1 for 1 cycle, no done, acc unchanged; op 11: err, no change.
REQ-036 Hold in_valid during ADD: in_ready = 0 and no second accept until the done cycle; the next ADD 0001 sees the updated acc.
REQ-037 Assert rst_n = 0 at ADD cycle 2: all outputs 0 asynchronously, no done after release, and in_ready = 1 in the first cycle after release.
REQ-038 Random legal operands (1000 commands): acc matches a decimal reference model modulo 10^DIGITS, and acc_ovf matches the model.

Source files
------------

// File: rtl/bcd_serial_accum_pkg.sv
// Shared encodings and helpers for the serial BCD accumulator.
// Digit width, command opcodes, FSM state encoding and an operand digit check.
package bcd_serial_accum_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Two bits wide so the unused encodings stay reachable and get recovered.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADD  = 2'b01
    } state_e;

    // True when every one of the low n digits of v is in 0..9.
    function automatic logic bcd_is_valid(input logic [31:0] v, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < n && v[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_serial_accum_digit_add.sv
// Combinational single-digit BCD adder: a + b + cin with decimal correction.
import bcd_serial_accum_pkg::*;

module bcd_digit_add (
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);

    logic [4:0] s;
    logic [4:0] s_adj;

    always_comb begin
        s     = 5'(a) + 5'(b) + 5'(cin);
        s_adj = s + 5'd6;
        if (s > 5'd9) begin
            sum  = s_adj[3:0];
            cout = 1'b1;
        end else begin
            sum  = s[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_accum.sv
// Packed-BCD accumulator with ADD (one digit per cycle, LSD first), LOAD and CLEAR.
// The accumulator only updates at command completion, so ADD is atomic to observers.
import bcd_serial_accum_pkg::*;

module bcd_serial_accum #(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic [BCD_W*DIGITS-1:0] in_bcd,
    output logic [BCD_W*DIGITS-1:0] acc,
    output logic                    acc_ovf,
    output logic                    done,
    output logic                    err,
    output logic                    busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e                             state_q, state_d;
    logic [DIGITS-1:0][BCD_W-1:0]       acc_q, acc_d;
    logic [DIGITS-1:0][BCD_W-1:0]       opnd_q, opnd_d;
    logic [DIGITS-1:0][BCD_W-1:0]       work_q, work_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               carry_q, carry_d;
    logic                               ovf_q, ovf_d;
    logic                               done_q, done_d;
    logic                               err_q, err_d;
    logic                               busy_q, busy_d;

    logic [BCD_W-1:0] dig_sum;
    logic             dig_cout;
    logic             in_ok;

    // One adder, time-shared across digits by the running index.
    bcd_digit_add u_digit_add (
        .a    (acc_q[idx_q]),
        .b    (opnd_q[idx_q]),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    assign in_ok = bcd_is_valid(32'(in_bcd), DIGITS);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        work_d  = work_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (op_e'(in_op))
                        OP_ADD: begin
                            if (in_ok) begin
                                opnd_d  = in_bcd;
                                work_d  = '0;
                                idx_d   = '0;
                                carry_d = 1'b0;
                                busy_d  = 1'b1;
                                state_d = ST_ADD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_LOAD: begin
                            if (in_ok) begin
                                acc_d  = in_bcd;
                                ovf_d  = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            acc_d  = '0;
                            ovf_d  = 1'b0;
                            done_d = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_ADD: begin
                work_d[idx_q] = dig_sum;
                carry_d       = dig_cout;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    // Final digit: commit the whole sum in one edge.
                    acc_d   = work_d;
                    ovf_d   = ovf_q | dig_cout;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            opnd_q  <= '0;
            work_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign acc      = acc_q;
    assign acc_ovf  = ovf_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bcd_serial_accum.sv
// Directed checks plus a decimal reference model over random legal commands.
module tb_bcd_serial_accum;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic [15:0] in_bcd = '0;
    logic        in_ready;
    logic [15:0] acc;
    logic        acc_ovf, done, err, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_serial_accum #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_bcd   (in_bcd),
        .acc      (acc),
        .acc_ovf  (acc_ovf),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; returns in cycle T+1.
    task automatic send(input logic [1:0] op, input logic [15:0] v);
        in_valid = 1'b1;
        in_op    = op;
        in_bcd   = v;
        step();
        in_valid = 1'b0;
        in_bcd   = '0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        chk(tag, done, 1);
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int d;
        d = n;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    initial begin
        int m;
        logic movf;
        int seen;
        int r;
        int v;

        step();
        step();
        chk("rst_acc",  acc, 0);
        chk("rst_ovf",  acc_ovf, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        chk("rel_ready", in_ready, 1);

        // LOAD 1234, ADD 0766 -> 2000
        send(2'b01, 16'h1234);
        chk("load_done", done, 1);
        chk("load_acc",  acc, 16'h1234);
        send(2'b00, 16'h0766);
        chk("add_busy1",  busy, 1);
        chk("add_ready1", in_ready, 0);
        chk("add_hold1",  acc, 16'h1234);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("add_busy", busy, 1);
            chk("add_hold", acc, 16'h1234);
            chk("add_nodone", done, 0);
        end
        step();
        chk("add_done", done, 1);
        chk("add_busy_off", busy, 0);
        chk("add_acc", acc, 16'h2000);
        chk("add_ovf", acc_ovf, 0);

        // Overflow wrap, sticky flag, CLEAR
        send(2'b01, 16'h9999);
        send(2'b00, 16'h0001);
        wait_done("ovf_done");
        chk("ovf_acc", acc, 16'h0000);
        chk("ovf_flag", acc_ovf, 1);
        step();
        chk("ovf_pulse", done, 0);
        send(2'b00, 16'h0005);
        wait_done("sticky_done");
        chk("sticky_acc", acc, 16'h0005);
        chk("sticky_ovf", acc_ovf, 1);
        send(2'b10, 16'h5555);
        chk("clr_done", done, 1);
        chk("clr_acc", acc, 16'h0000);
        chk("clr_ovf", acc_ovf, 0);

        // Rejections
        send(2'b01, 16'h4321);
        send(2'b00, 16'h12A4);
        chk("bad_add_err",  err, 1);
        chk("bad_add_done", done, 0);
        chk("bad_add_acc",  acc, 16'h4321);
        chk("bad_add_rdy",  in_ready, 1);
        step();
        chk("bad_add_pulse", err, 0);
        send(2'b01, 16'h99F9);
        chk("bad_load_err", err, 1);
        chk("bad_load_acc", acc, 16'h4321);
        send(2'b11, 16'h0000);
        chk("rsvd_err",  err, 1);
        chk("rsvd_done", done, 0);
        chk("rsvd_acc",  acc, 16'h4321);

        // Held in_valid during ADD, back-to-back accept in the done cycle
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_bcd   = 16'h0001;
        step();
        chk("hold_ready0", in_ready, 0);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("hold_ready", in_ready, 0);
        end
        step();
        chk("hold_done", done, 1);
        chk("hold_acc", acc, 16'h4322);
        chk("hold_ready_done", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("b2b_busy", busy, 1);
        wait_done("b2b_done");
        chk("b2b_acc", acc, 16'h4323);

        // Asynchronous reset in ADD cycle 2
        send(2'b00, 16'h0100);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_acc",  acc, 0);
        chk("arst_ovf",  acc_ovf, 0);
        chk("arst_done", done, 0);
        chk("arst_err",  err, 0);
        chk("arst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        chk("arst_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) seen++;
        end
        chk("arst_nodone", seen, 0);
        chk("arst_acc_after", acc, 0);

        // Random legal commands against a decimal model
        m = 0;
        movf = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            r = int'($urandom_range(0, 9));
            v = int'($urandom_range(0, 9999));
            if (r < 7) begin
                send(2'b00, to_bcd(v));
                wait_done("rand_add_done");
                m = m + v;
                if (m > 9999) begin
                    m = m - 10000;
                    movf = 1'b1;
                end
            end else if (r < 9) begin
                send(2'b01, to_bcd(v));
                m = v;
                movf = 1'b0;
            end else begin
                send(2'b10, to_bcd(v));
                m = 0;
                movf = 1'b0;
            end
            chk("rand_acc", {15'd0, acc_ovf, acc}, {15'd0, movf, to_bcd(m)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
